// File: rtl/rv32i_pkg.sv
// Shared RV32 pipeline types: word size, canonical NOP, and the IF/ID payload
// that decode consumes.
package rv32i_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } if_id_t;
endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-stage bus: combinational imem port, EX redirect, and IF/ID handshake.
// The master side is the fetch unit, the slave side is its environment.
interface rv32i_fetch_unit_if #(parameter int INST_WIDTH = 32);
  logic [INST_WIDTH-1:0] o_imem_addr;
  logic [INST_WIDTH-1:0] i_imem_inst;
  logic                  i_redirect_valid;
  logic [INST_WIDTH-1:0] i_redirect_pc;
  logic                  o_id_valid;
  logic                  i_id_ready;
  logic [INST_WIDTH-1:0] o_id_pc;
  logic [INST_WIDTH-1:0] o_id_pc4;
  logic [INST_WIDTH-1:0] o_id_inst;
  logic                  o_misalign;

  modport master (
    output o_imem_addr, o_id_valid, o_id_pc, o_id_pc4, o_id_inst, o_misalign,
    input  i_imem_inst, i_redirect_valid, i_redirect_pc, i_id_ready
  );

  modport slave (
    input  o_imem_addr, o_id_valid, o_id_pc, o_id_pc4, o_id_inst, o_misalign,
    output i_imem_inst, i_redirect_valid, i_redirect_pc, i_id_ready
  );
endinterface

// File: rtl/rv32i_if_id_reg.sv
// Valid/ready pipeline register with flush. Flush drops valid but keeps the
// payload, so downstream sees stable (stale) data while the bubble passes.
module rv32i_if_id_reg #(
  parameter int           W        = 96,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign o_ready = !valid_q || i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (o_ready) begin
      valid_d = i_valid;
      if (i_valid) data_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32 instruction fetch: owns the PC, reads the combinational imem, and
// feeds decode through the IF/ID register. EX redirects squash in-flight work.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter int                    INST_WIDTH = XLEN,
  parameter logic [INST_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rv32i_fetch_unit_if.master  bus
);
  localparam int PW = 3 * INST_WIDTH;
  localparam logic [PW-1:0] PAYLOAD_RST = {{INST_WIDTH{1'b0}}, {INST_WIDTH{1'b0}}, RV32I_NOP};

  logic [INST_WIDTH-1:0] pc_q, pc_d;
  logic                  mis_q, mis_d;
  logic                  slot_free;
  logic                  id_valid;
  logic [PW-1:0]         fetch_data, id_data;
  if_id_t                id_s;

  // Every PC add wraps modulo 2^INST_WIDTH.
  assign fetch_data = {pc_q, pc_q + INST_WIDTH'(4), bus.i_imem_inst};

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (bus.i_redirect_valid) begin
      pc_d  = {bus.i_redirect_pc[INST_WIDTH-1:2], 2'b00};
      mis_d = |bus.i_redirect_pc[1:0];
    end else if (slot_free) begin
      pc_d  = pc_q + INST_WIDTH'(4);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  rv32i_if_id_reg #(.W(PW), .RST_DATA(PAYLOAD_RST)) u_if_id (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (bus.i_redirect_valid),
    .i_valid (1'b1),
    .o_ready (slot_free),
    .i_data  (fetch_data),
    .o_valid (id_valid),
    .i_ready (bus.i_id_ready),
    .o_data  (id_data)
  );

  assign id_s = {id_valid, id_data};

  assign bus.o_imem_addr = pc_q;
  assign bus.o_id_valid  = id_s.valid;
  assign bus.o_id_pc     = id_s.pc;
  assign bus.o_id_pc4    = id_s.pc4;
  assign bus.o_id_inst   = id_s.inst;
  assign bus.o_misalign  = mis_q;
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: imem word k holds 0x1000_0000 + k.
module tb_rv32i_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_fetch_unit_if #(.INST_WIDTH(32)) bus ();

  rv32i_fetch_unit #(.INST_WIDTH(32), .RESET_PC(32'h0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  assign bus.i_imem_inst = 32'h1000_0000 + {2'b00, bus.o_imem_addr[31:2]};

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    logic        e_mis;
  } vec_t;

  localparam int NV = 23;
  vec_t vec [NV];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", idx);
    check({tag, ".valid"}, {31'b0, bus.o_id_valid}, {31'b0, v.e_v});
    check({tag, ".pc"},    bus.o_id_pc,   v.e_pc);
    check({tag, ".pc4"},   bus.o_id_pc4,  v.e_pc4);
    check({tag, ".inst"},  bus.o_id_inst, v.e_inst);
    check({tag, ".addr"},  bus.o_imem_addr, v.e_addr);
    check({tag, ".mis"},   {31'b0, bus.o_misalign}, {31'b0, v.e_mis});
  endtask

  initial begin
    //            rst rv  rpc            rdy  v  pc            pc4           inst           addr          mis
    vec[0]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,       32'h0,        32'h13,        32'h0,        1'b0};
    vec[1]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0,       32'h4,        32'h1000_0000, 32'h4,        1'b0};
    vec[2]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h4,       32'h8,        32'h1000_0001, 32'h8,        1'b0};
    vec[3]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h8,       32'hC,        32'h1000_0002, 32'hC,        1'b0};
    vec[4]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h8,       32'hC,        32'h1000_0002, 32'hC,        1'b0};
    vec[5]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h8,       32'hC,        32'h1000_0002, 32'hC,        1'b0};
    vec[6]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h8,       32'hC,        32'h1000_0002, 32'hC,        1'b0};
    vec[7]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'hC,       32'h10,       32'h1000_0003, 32'h10,       1'b0};
    vec[8]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h10,      32'h14,       32'h1000_0004, 32'h14,       1'b0};
    vec[9]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h10,      32'h14,       32'h1000_0004, 32'h14,       1'b0};
    // redirect while stalled: held instruction squashed, payload kept
    vec[10] = '{1'b0,1'b1,32'h40,       1'b0,1'b0,32'h10,      32'h14,       32'h1000_0004, 32'h40,       1'b0};
    vec[11] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h40,      32'h44,       32'h1000_0010, 32'h44,       1'b0};
    vec[12] = '{1'b0,1'b1,32'h46,       1'b1,1'b0,32'h40,      32'h44,       32'h1000_0010, 32'h44,       1'b1};
    vec[13] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h44,      32'h48,       32'h1000_0011, 32'h48,       1'b0};
    vec[14] = '{1'b0,1'b1,32'hFFFF_FFFC,1'b1,1'b0,32'h44,      32'h48,       32'h1000_0011, 32'hFFFF_FFFC,1'b0};
    vec[15] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'hFFFF_FFFC,32'h0,       32'h4FFF_FFFF, 32'h0,        1'b0};
    vec[16] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0,       32'h4,        32'h1000_0000, 32'h4,        1'b0};
    // back-to-back redirects, last wins
    vec[17] = '{1'b0,1'b1,32'h80,       1'b1,1'b0,32'h0,       32'h4,        32'h1000_0000, 32'h80,       1'b0};
    vec[18] = '{1'b0,1'b1,32'h100,      1'b1,1'b0,32'h0,       32'h4,        32'h1000_0000, 32'h100,      1'b0};
    vec[19] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h100,     32'h104,      32'h1000_0040, 32'h104,      1'b0};
    vec[20] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h100,     32'h104,      32'h1000_0040, 32'h104,      1'b0};
    // reset beats a misaligned redirect mid-stall
    vec[21] = '{1'b1,1'b1,32'h47,       1'b0,1'b0,32'h0,       32'h0,        32'h13,        32'h0,        1'b0};
    vec[22] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0,       32'h4,        32'h1000_0000, 32'h4,        1'b0};

    rst = 1'b1;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_id_ready       = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst                  = vec[i].rst;
      bus.i_redirect_valid = vec[i].rv;
      bus.i_redirect_pc    = vec[i].rpc;
      bus.i_id_ready       = vec[i].rdy;
      @(posedge clk);
      #1;
      check_all(i, vec[i]);
    end

    // streaming throughput: one instruction per cycle, no gaps or repeats
    rst = 1'b0;
    bus.i_redirect_valid = 1'b0;
    bus.i_id_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stream%0d.valid", k), {31'b0, bus.o_id_valid}, 32'd1);
      check($sformatf("stream%0d.pc", k), bus.o_id_pc, 32'(4 * k));
      check($sformatf("stream%0d.inst", k), bus.o_id_inst, 32'h1000_0000 + 32'(k));
    end

    // single misalign pulse: high the cycle after the redirect, low after
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h0000_0203;
    @(posedge clk);
    #1;
    bus.i_redirect_valid = 1'b0;
    check("pulse.hi", {31'b0, bus.o_misalign}, 32'd1);
    check("pulse.addr", bus.o_imem_addr, 32'h200);
    @(posedge clk);
    #1;
    check("pulse.lo", {31'b0, bus.o_misalign}, 32'd0);
    check("pulse.pc", bus.o_id_pc, 32'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
